// File: rtl/packet_pkg.sv
// packet_pkg: constants and FSM encoding shared by the packet ingress arbiter and decoder
package packet_pkg;
  localparam int ETH_MTU_BYTES = 1522;
  localparam int WORD_BYTES = 4;
  localparam logic [15:0] VLAN_TPID = 16'h8100;
  localparam logic [3:0] KEEP_FULL = 4'b1111;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, searching upward from ptr+1 with wrap-around
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] cand;
  // walk from the farthest candidate back so the nearest requester after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        gnt = '0;
        gnt[cand] = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/packet_ingress_arbiter.sv
// packet_ingress_arbiter: packet-granular round-robin mux of N ingress streams onto the
// decoder input, with MTU truncation and an idle gap after every forwarded last beat.
module packet_ingress_arbiter
  import packet_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int MAX_WORDS  = 381,
  parameter int GAP_CYCLES = 1,
  localparam int PW = $clog2(N_PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*N_PORTS-1:0]  in_data,
  input  logic [N_PORTS-1:0]     in_valid,
  input  logic [N_PORTS-1:0]     in_last,
  input  logic [4*N_PORTS-1:0]   in_keep,
  output logic [N_PORTS-1:0]     in_ready,
  output logic [31:0]            packet4_byte,
  output logic                   data_valid,
  output logic                   last_valid,
  output logic [3:0]             keep,
  output logic [PW-1:0]          grant_port,
  output logic                   busy,
  output logic                   trunc_err
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  arb_state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, arb_idx;
  logic [8:0] word_cnt_q, word_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] data_q, data_d, sel_data;
  logic [3:0] keep_q, keep_d, sel_keep;
  logic dv_q, dv_d, lv_q, lv_d, trunc_q, trunc_d;
  logic [N_PORTS-1:0] arb_gnt;
  logic sel_valid, sel_last, at_max, gap_done;

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .req(in_valid),
    .ptr(rr_ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign sel_data = in_data[{grant_q, 5'd0} +: 32];
  assign sel_keep = in_keep[{grant_q, 2'd0} +: 4];
  assign sel_valid = in_valid[grant_q];
  assign sel_last = in_last[grant_q];
  assign at_max = word_cnt_q == 9'(MAX_WORDS - 1);
  assign gap_done = gap_cnt_q == GW'(GAP_CYCLES - 1);
  assign in_ready = (state_q == XFER || state_q == DRAIN) ? N_PORTS'(1) << grant_q : '0;
  assign packet4_byte = data_q;
  assign data_valid = dv_q;
  assign last_valid = lv_q;
  assign keep = keep_q;
  assign grant_port = grant_q;
  assign busy = state_q != IDLE;
  assign trunc_err = trunc_q;

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d = data_q;
    keep_d = keep_q;
    dv_d = 1'b0;
    lv_d = 1'b0;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: if (|arb_gnt) begin
        state_d = XFER;
        grant_d = arb_idx;
        rr_ptr_d = arb_idx;
        word_cnt_d = '0;
      end
      XFER: if (sel_valid) begin
        // the MTU-th word closes an oversize packet as a full-keep last beat
        dv_d = 1'b1;
        data_d = sel_data;
        keep_d = (at_max && !sel_last) ? KEEP_FULL : sel_keep;
        lv_d = sel_last || at_max;
        trunc_d = at_max && !sel_last;
        word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 9'd1;
        state_d = sel_last ? GAP : at_max ? DRAIN : XFER;
        gap_cnt_d = '0;
      end
      DRAIN: if (sel_valid && sel_last) begin
        state_d = GAP;
        gap_cnt_d = '0;
      end
      default: begin
        state_d = gap_done ? IDLE : GAP;
        gap_cnt_d = gap_done ? '0 : gap_cnt_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_ptr_q <= PW'(N_PORTS - 1);
      grant_q <= '0;
      word_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q <= '0;
      keep_q <= '0;
      dv_q <= 1'b0;
      lv_q <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q <= data_d;
      keep_q <= keep_d;
      dv_q <= dv_d;
      lv_q <= lv_d;
      trunc_q <= trunc_d;
    end
  end
endmodule
